ps2_key_matrix: RTL and testbench

Parametrised PS/2 keyboard front end. It turns a raw PS/2 clock/data pair into a ROWS x COLS key matrix that the machine scans as a row-select/column-sense port. Scancode-to-key mapping sits in a runtime-loadable map RAM, so one block serves any target machine. Adds E0/E1 prefix handling, frame error detection, a receive watchdog and a global key release.

---
 rtl/ps2_key_matrix_if.sv | 48 ++++
 rtl/ps2_key_matrix.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ps2_key_matrix.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_matrix_if.sv
// ----------------------------------------------------------------------------
// ps2_key_matrix_if
//   Groups the PS/2 front end's non-clock signals into one bundle.
//   master : the machine/host side. It drives ce, the raw PS/2 pair, the map
//            write port, key_clear and the row select. It receives the column
//            sense and the receive status.
//   slave  : the keyboard front end (ps2_key_matrix).
//   Signals:
//     ce        sampling clock enable
//     ps2       [0]=PS/2 clock, [1]=PS/2 data (already synchronised)
//     map_we    map RAM write strobe
//     map_addr  {ext, scancode}
//     map_data  {valid, row, col}
//     key_clear release all keys
//     a         row select, active high
//     q         column sense, active high
//     code      last accepted scancode byte
//     code_stb  one-clock pulse when code updates
//     frame_err one-clock pulse on parity, stop-bit or timeout error
// ----------------------------------------------------------------------------
interface ps2_key_matrix_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = 3,
  parameter int CW   = 3
);
  logic                ce;
  logic [1:0]          ps2;
  logic                map_we;
  logic [8:0]          map_addr;
  logic [RW+CW:0]      map_data;
  logic                key_clear;
  logic [ROWS-1:0]     a;
  logic [COLS-1:0]     q;
  logic [7:0]          code;
  logic                code_stb;
  logic                frame_err;

  modport master (
    output ce, ps2, map_we, map_addr, map_data, key_clear, a,
    input  q, code, code_stb, frame_err
  );

  modport slave (
    input  ce, ps2, map_we, map_addr, map_data, key_clear, a,
    output q, code, code_stb, frame_err
  );
endinterface

// File: rtl/ps2_key_matrix.sv
// ----------------------------------------------------------------------------
// ps2_key_matrix
//   PS/2 keyboard front end producing a ROWS x COLS key matrix scanned through
//   a row-select / column-sense port. Scancodes are translated through a
//   runtime-loadable 512-entry map RAM indexed by {ext, scancode}.
//
//   Pipeline (in ce ticks):
//     tick 0 : stop bit sampled, code loaded, code_stb pulses
//     tick 1 : decoder acts on code (prefix flags / map RAM read issued)
//     tick 2 : map entry applied to the matrix
//
//   Ports:
//     clock     system clock
//     reset_n   asynchronous active-low reset (map RAM is not cleared)
//     bus       ps2_key_matrix_if.slave; see the interface file for signals
// ----------------------------------------------------------------------------
module ps2_key_matrix #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 2047,
  parameter int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CW      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  ps2_key_matrix_if.slave      bus
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int MW  = 1 + RW + CW;

  // --------------------------------------------------------------------------
  // PS/2 clock glitch filter
  // --------------------------------------------------------------------------
  logic [FILTER-1:0] filt_reg;
  logic [FILTER-1:0] filt_next;
  logic              clk_f_reg;
  logic              fall;
  logic              data_in;

  assign filt_next = {filt_reg[FILTER-2:0], bus.ps2[0]};
  assign data_in   = bus.ps2[1];
  // A fall is the filtered clock leaving 1 on the tick the window fills with 0s.
  assign fall      = bus.ce && clk_f_reg && (filt_next == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt_reg  <= '1;
      clk_f_reg <= 1'b1;
    end else if (bus.ce) begin
      filt_reg <= filt_next;
      if (filt_next == '1)
        clk_f_reg <= 1'b1;
      else if (filt_next == '0)
        clk_f_reg <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Frame receiver and watchdog
  // --------------------------------------------------------------------------
  logic [3:0]     cnt_reg;
  logic [7:0]     shift_reg;
  logic           par_reg;
  logic [WDW-1:0] wd_reg;
  logic [7:0]     code_reg;
  logic           code_stb_reg;
  logic           err_reg;
  logic           stop_evt;
  logic           good;
  logic           bad;
  logic           tmo;

  assign stop_evt = fall && (cnt_reg == 4'd10);
  // Odd parity: data bits plus parity must XOR to 1; stop must be 1.
  assign good     = stop_evt && (^{shift_reg, par_reg}) && data_in;
  assign bad      = stop_evt && !good;
  // Watchdog only runs between falls of a partial frame.
  assign tmo      = bus.ce && !fall && (cnt_reg != 4'd0) &&
                    (wd_reg == WDW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg   <= 4'd0;
      shift_reg <= 8'd0;
      par_reg   <= 1'b0;
      wd_reg    <= '0;
    end else if (fall) begin
      wd_reg <= '0;
      case (cnt_reg)
        4'd0: begin
          // A start bit sampled high is line noise; stay idle.
          if (!data_in)
            cnt_reg <= 4'd1;
        end
        4'd9: begin
          par_reg <= data_in;
          cnt_reg <= 4'd10;
        end
        4'd10: begin
          cnt_reg <= 4'd0;
        end
        default: begin
          // Data bits arrive LSB first.
          shift_reg <= {data_in, shift_reg[7:1]};
          cnt_reg   <= cnt_reg + 4'd1;
        end
      endcase
    end else if (bus.ce) begin
      if (tmo) begin
        cnt_reg <= 4'd0;
        wd_reg  <= '0;
      end else if (cnt_reg != 4'd0) begin
        wd_reg <= wd_reg + 1'b1;
      end else begin
        wd_reg <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      code_reg     <= 8'd0;
      code_stb_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      code_stb_reg <= good;
      err_reg      <= bad || tmo;
      if (good)
        code_reg <= shift_reg;
    end
  end

  assign bus.code      = code_reg;
  assign bus.code_stb  = code_stb_reg;
  assign bus.frame_err = err_reg;

  // --------------------------------------------------------------------------
  // Scancode decoder
  // --------------------------------------------------------------------------
  logic       dec_pend_reg;
  logic [2:0] skip_reg;
  logic       ext_reg;
  logic       brk_reg;
  logic       brk_lat_reg;
  logic       look_pend_reg;

  logic dec_go;
  logic is_e0;
  logic is_f0;
  logic is_e1;
  logic is_aa;
  logic is_ack;
  logic lookup_go;
  logic aa_clr;

  always_comb begin
    dec_go = bus.ce && dec_pend_reg && (skip_reg == 3'd0);
    is_e0  = 1'b0;
    is_f0  = 1'b0;
    is_e1  = 1'b0;
    is_aa  = 1'b0;
    is_ack = 1'b0;
    case (code_reg)
      8'hE0: is_e0 = 1'b1;
      8'hF0: is_f0 = 1'b1;
      8'hE1: is_e1 = 1'b1;
      8'hAA: is_aa = 1'b1;
      // Keyboard responses carrying no key information.
      8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_ack = 1'b1;
      default: ;
    endcase
    lookup_go = dec_go && !(is_e0 || is_f0 || is_e1 || is_aa || is_ack);
    aa_clr    = dec_go && is_aa;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dec_pend_reg  <= 1'b0;
      skip_reg      <= 3'd0;
      ext_reg       <= 1'b0;
      brk_reg       <= 1'b0;
      brk_lat_reg   <= 1'b0;
      look_pend_reg <= 1'b0;
    end else begin
      // The byte loaded on the stop-bit tick is decoded on the next ce.
      if (good)
        dec_pend_reg <= 1'b1;
      else if (bus.ce)
        dec_pend_reg <= 1'b0;

      if (bus.ce)
        look_pend_reg <= lookup_go;

      if (bus.ce && dec_pend_reg && (skip_reg != 3'd0))
        skip_reg <= skip_reg - 3'd1;

      if (dec_go) begin
        if (is_e0) begin
          ext_reg <= 1'b1;
        end else if (is_f0) begin
          brk_reg <= 1'b1;
        end else if (is_e1) begin
          // The rest of the Pause sequence is seven bytes; swallow them.
          skip_reg <= 3'd7;
          ext_reg  <= 1'b0;
          brk_reg  <= 1'b0;
        end else if (is_aa) begin
          ext_reg <= 1'b0;
          brk_reg <= 1'b0;
        end else if (lookup_go) begin
          brk_lat_reg <= brk_reg;
          ext_reg     <= 1'b0;
          brk_reg     <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Map RAM: 512 x {valid, row, col}, registered read, read-before-write
  // --------------------------------------------------------------------------
  logic [MW-1:0] map_mem [0:511];
  logic [MW-1:0] map_rd_reg;

  always_ff @(posedge clock) begin
    if (bus.map_we)
      map_mem[bus.map_addr] <= bus.map_data;
  end

  always_ff @(posedge clock) begin
    if (lookup_go)
      map_rd_reg <= map_mem[{ext_reg, code_reg}];
  end

  // --------------------------------------------------------------------------
  // Key matrix, stored column-major so each column sense is one AND-OR
  // --------------------------------------------------------------------------
  logic [COLS-1:0][ROWS-1:0] key_reg;
  logic                      rd_valid;
  logic [RW-1:0]             rd_row;
  logic [CW-1:0]             rd_col;
  logic                      key_hit;

  assign rd_valid = map_rd_reg[MW-1];
  assign rd_row   = map_rd_reg[RW+CW-1:CW];
  assign rd_col   = map_rd_reg[CW-1:0];
  // Entries pointing outside the matrix are treated as unmapped.
  assign key_hit  = bus.ce && look_pend_reg && rd_valid &&
                    (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_reg <= '0;
    end else if (bus.key_clear || aa_clr) begin
      // Clearing wins over a lookup landing in the same cycle.
      key_reg <= '0;
    end else if (key_hit) begin
      key_reg[rd_col][rd_row] <= ~brk_lat_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      assign bus.q[gi] = |(bus.a & key_reg[gi]);
    end
  endgenerate

endmodule

// File: tb/tb_ps2_key_matrix.sv
module tb_ps2_key_matrix;
  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 64;
  localparam int RW      = 3;
  localparam int CW      = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ps2_key_matrix_if #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) bus();

  ps2_key_matrix #(
    .ROWS(ROWS), .COLS(COLS), .FILTER(FILTER), .TIMEOUT(TIMEOUT),
    .RW(RW), .CW(CW)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] code;
  } ev_t;

  ev_t sb[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every code_stb / frame_err pulse pops one expected event.
  always @(negedge clock) begin
    if (reset_n && (bus.code_stb || bus.frame_err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got stb=%0b err=%0b code=%0h expected none",
                 bus.code_stb, bus.frame_err, bus.code);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (e.err) begin
          $display("event frame_err");
          chk("event_kind_err", {30'd0, bus.frame_err, bus.code_stb}, 32'h2);
        end else begin
          $display("event code %02h", bus.code);
          chk("event_kind_code", {30'd0, bus.frame_err, bus.code_stb}, 32'h1);
          chk("event_code", {24'd0, bus.code}, {24'd0, e.code});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit stop);
    logic p;
    p = (~^b) ^ bad_par;
    return {stop, p, b, 1'b0};
  endfunction

  // Drive the first n bits; returns 1 time unit after the last fall edge.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2[1] = bits[i];
      bus.ps2[0] = 1'b1;
      repeat (FILTER + 2) tick();
      bus.ps2[0] = 1'b0;
      repeat (FILTER) tick();
    end
  endtask

  task automatic idle();
    bus.ps2[0] = 1'b1;
    bus.ps2[1] = 1'b1;
    repeat (FILTER + 2) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    sb.push_back('{err: 1'b0, code: b});
    send_bits(mk(b, 1'b0, 1'b1), 11);
    idle();
  endtask

  task automatic map_write(input bit ext, input logic [7:0] sc, input int row, input int col);
    bus.map_we   = 1'b1;
    bus.map_addr = {ext, sc};
    bus.map_data = {1'b1, 3'(row), 3'(col)};
    tick();
    bus.map_we = 1'b0;
  endtask

  task automatic chk_q(input string name, input logic [7:0] a, input logic [7:0] exp);
    bus.a = a;
    #1;
    chk(name, {24'd0, bus.q}, {24'd0, exp});
  endtask

  task automatic drained(input string name);
    repeat (4) tick();
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ce        = 1'b1;
    bus.ps2       = 2'b11;
    bus.map_we    = 1'b0;
    bus.map_addr  = 9'd0;
    bus.map_data  = '0;
    bus.key_clear = 1'b0;
    bus.a         = 8'hFF;

    // Reset state
    repeat (3) tick();
    chk_q("reset_q", 8'hFF, 8'h00);
    chk("reset_code", {24'd0, bus.code}, 32'h0);
    chk("reset_stb", {31'd0, bus.code_stb}, 32'h0);
    chk("reset_err", {31'd0, bus.frame_err}, 32'h0);
    reset_n = 1'b1;
    repeat (2) tick();

    map_write(1'b0, 8'h1C, 0, 1);
    map_write(1'b1, 8'h75, 6, 3);
    map_write(1'b0, 8'h75, 2, 0);
    map_write(1'b0, 8'h14, 1, 2);
    map_write(1'b0, 8'h77, 3, 4);

    // Make 1C with latency check: key appears exactly 2 ce after the stop fall
    bus.a = 8'h01;
    sb.push_back('{err: 1'b0, code: 8'h1C});
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
    chk_q("lat_0", 8'h01, 8'h00);
    tick();
    chk_q("lat_1", 8'h01, 8'h00);
    tick();
    chk_q("lat_2", 8'h01, 8'h02);
    idle();
    chk_q("row1_sel", 8'h02, 8'h00);
    chk_q("row0_sel", 8'h01, 8'h02);

    // Break 1C
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk_q("break_1c", 8'h01, 8'h00);

    // Extended 75 then plain 75
    send_byte(8'hE0);
    send_byte(8'h75);
    chk_q("ext75_row6", 8'h40, 8'h08);
    chk_q("ext75_row2", 8'h04, 8'h00);
    send_byte(8'h75);
    chk_q("plain75_row2", 8'h04, 8'h01);
    chk_q("plain75_row6", 8'h40, 8'h08);
    drained("drain_basic");

    // Bad parity and bad stop
    sb.push_back('{err: 1'b1, code: 8'h00});
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11);
    idle();
    chk_q("badpar_matrix", 8'hFF, 8'h09);
    sb.push_back('{err: 1'b1, code: 8'h00});
    send_bits(mk(8'h1C, 1'b0, 1'b0), 11);
    idle();
    chk_q("badstop_matrix", 8'hFF, 8'h09);
    chk("code_kept", {24'd0, bus.code}, 32'h75);
    drained("drain_err");

    // Short low glitch with data low must not start a frame
    bus.ps2[1] = 1'b0;
    bus.ps2[0] = 1'b0;
    repeat (FILTER - 1) tick();
    idle();

    // Partial frame then watchdog timeout
    sb.push_back('{err: 1'b1, code: 8'h00});
    send_bits(mk(8'h1C, 1'b0, 1'b1), 4);
    bus.ps2[0] = 1'b1;
    bus.ps2[1] = 1'b1;
    repeat (TIMEOUT + 2) tick();
    drained("drain_timeout");
    send_byte(8'h1C);
    chk_q("after_timeout", 8'h01, 8'h02);
    chk_q("multi_row", 8'h45, 8'h0B);

    // Pause sequence is swallowed
    send_byte(8'hE1);
    send_byte(8'h14);
    send_byte(8'h77);
    send_byte(8'hE1);
    send_byte(8'hF0);
    send_byte(8'h14);
    send_byte(8'hF0);
    send_byte(8'h77);
    drained("drain_pause");
    chk_q("pause_matrix", 8'hFF, 8'h0B);

    // Self-test pass clears the matrix
    send_byte(8'hAA);
    chk_q("aa_clear", 8'hFF, 8'h00);

    // Re-press and key_clear with ce low
    send_byte(8'h1C);
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'h75);
    chk_q("repress", 8'hFF, 8'h0B);
    bus.ce = 1'b0;
    bus.key_clear = 1'b1;
    tick();
    bus.key_clear = 1'b0;
    chk_q("key_clear", 8'hFF, 8'h00);
    bus.ce = 1'b1;
    drained("drain_repress");

    // Async reset mid-frame with a key held
    send_byte(8'h1C);
    chk_q("pre_reset", 8'h01, 8'h02);
    send_bits(mk(8'h3A, 1'b0, 1'b1), 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk_q("reset_async_q", 8'hFF, 8'h00);
    chk("reset_async_code", {24'd0, bus.code}, 32'h0);
    chk("reset_async_flags", {30'd0, bus.code_stb, bus.frame_err}, 32'h0);
    bus.ps2 = 2'b11;
    repeat (3) tick();
    reset_n = 1'b1;
    idle();
    send_byte(8'h1C);
    chk_q("map_retained", 8'h01, 8'h02);
    drained("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
